// File: rtl/led_scheduler.sv
// Two-requester LED blink scheduler: round-robin grant, blinks the LED
// count times for the owner, pulses done, then holds off for a fixed gap.
module led_scheduler #(
  parameter int unsigned HALF_PERIOD = 12,
  parameter int unsigned GAP         = 24,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] count0,
  input  logic [CNT_W-1:0] count1,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy,
  output logic             led
);

  localparam int unsigned PH_MAX = (HALF_PERIOD > GAP) ? HALF_PERIOD : GAP;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] HP_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_ZERO,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             led_q, led_d;
  logic             pick_c;
  logic [CNT_W-1:0] cnt_c;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + PH_W'(1);
    remaining_d = remaining_q;
    last_d      = last_q;
    grant_d     = grant_q;
    done_d      = 2'b00;
    led_d       = led_q;
    // On a tie the requester that was not served last wins
    pick_c      = (req == 2'b11) ? ~last_q : req[1];
    cnt_c       = pick_c ? count1 : count0;

    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (|req) begin
          last_d      = pick_c;
          grant_d     = pick_c ? 2'b10 : 2'b01;
          remaining_d = cnt_c;
          if (cnt_c != '0) begin
            state_d = S_ON;
            led_d   = 1'b1;
          end else begin
            state_d = S_ZERO;
            led_d   = 1'b0;
          end
        end
      end
      S_ON: begin
        if (phase_q == HP_LAST) begin
          state_d = S_OFF;
          led_d   = 1'b0;
          phase_d = '0;
        end
      end
      S_OFF: begin
        if (phase_q == HP_LAST) begin
          phase_d     = '0;
          remaining_d = remaining_q - CNT_W'(1);
          // Stop at one remaining so the counter never wraps
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_GAP;
            grant_d = 2'b00;
            done_d  = grant_q;
          end else begin
            state_d = S_ON;
            led_d   = 1'b1;
          end
        end
      end
      S_ZERO: begin
        state_d = S_GAP;
        phase_d = '0;
        grant_d = 2'b00;
        done_d  = grant_q;
        led_d   = 1'b0;
      end
      S_GAP: begin
        if (phase_q == GAP_LAST) begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        grant_d = 2'b00;
        led_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; last-served resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
      last_q      <= 1'b1;
      grant_q     <= 2'b00;
      done_q      <= 2'b00;
      busy_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      led_q       <= led_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_scheduler.sv
// Bench for led_scheduler: table of transactions plus a reset corner case,
// checked by a negedge monitor against a queue of expected grants.
module tb_led_scheduler;

  localparam int unsigned HP = 12;
  localparam int unsigned GP = 24;
  localparam int unsigned CW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [CW-1:0] count0 = '0;
  logic [CW-1:0] count1 = '0;
  logic [1:0]    grant;
  logic [1:0]    done;
  logic          busy;
  logic          led;

  led_scheduler #(.HALF_PERIOD(HP), .GAP(GP), .CNT_W(CW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req),
    .count0 (count0),
    .count1 (count1),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .led    (led)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    req;
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
    int            drop_at;
    logic [1:0]    exp_grant;
  } vec_t;

  typedef struct {
    logic [1:0] grant;
    int         cnt;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[10];
  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    nmis++;
    $display("FAIL %s: bound expired or event not expected (cycle %0d)", name, cyc);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor state
  logic [1:0] grant_prev = 2'b00;
  logic       led_prev = 1'b0;
  logic       busy_prev = 1'b0;
  logic       active = 1'b0;
  logic       gap_pending = 1'b0;
  exp_t       cur;
  int         start_cyc = 0;
  int         done_cyc = 0;
  int         led_t = 0;
  int         blinks = 0;

  // Negedge monitor: timing of grant, LED phases, done and gap
  always @(negedge clock) begin
    if (!reset_n) begin
      active      = 1'b0;
      gap_pending = 1'b0;
      grant_prev  = 2'b00;
      led_prev    = 1'b0;
      busy_prev   = 1'b0;
    end else begin
      check("grant_onehot0", int'($onehot0(grant)), 1);
      check("led_without_owner", int'(led && (grant == 2'b00)), 0);

      if (grant_prev == 2'b00 && grant != 2'b00) begin
        if (sbq.size() == 0) begin
          fail_now("unexpected_grant");
        end else begin
          cur = sbq.pop_front();
          check("grant_value", int'(grant), int'(cur.grant));
          active    = 1'b1;
          start_cyc = cyc;
          led_t     = cyc;
          blinks    = 0;
        end
      end

      if (led && !led_prev) begin
        blinks++;
        if (blinks > 1) check("led_low_len", cyc - led_t, HP);
        led_t = cyc;
      end else if (!led && led_prev) begin
        check("led_high_len", cyc - led_t, HP);
        led_t = cyc;
      end

      if (done != 2'b00) begin
        if (!active) begin
          fail_now("unexpected_done");
        end else begin
          check("done_value", int'(done), int'(cur.grant));
          check("grant_at_done", int'(grant), 0);
          check("done_delay", cyc - start_cyc, (cur.cnt == 0) ? 1 : 2 * HP * cur.cnt);
          check("blink_count", blinks, cur.cnt);
          if (cur.cnt > 0) check("led_last_low", cyc - led_t, HP);
          active      = 1'b0;
          gap_pending = 1'b1;
          done_cyc    = cyc;
        end
      end

      if (busy_prev && !busy && gap_pending) begin
        check("gap_len", cyc - done_cyc, GP);
        gap_pending = 1'b0;
      end

      grant_prev = grant;
      led_prev   = led;
      busy_prev  = busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (busy) fail_now("idle_timeout");
  endtask

  task automatic wait_grant();
    int n = 0;
    while (grant == 2'b00 && n < 4) begin
      @(negedge clock);
      n++;
    end
    if (grant == 2'b00) fail_now("grant_timeout");
  endtask

  task automatic wait_done(input logic [1:0] g);
    int n = 0;
    while ((done & g) == 2'b00 && n < 7000) begin
      @(negedge clock);
      n++;
    end
    if ((done & g) == 2'b00) fail_now("done_timeout");
  endtask

  // Drive one transaction; counts are scrambled after the grant edge
  task automatic run_txn(input vec_t v);
    exp_t e;
    wait_idle();
    count0 = v.c0;
    count1 = v.c1;
    req    = req | v.req;
    e.grant = v.exp_grant;
    e.cnt   = v.exp_grant[0] ? int'(v.c0) : int'(v.c1);
    sbq.push_back(e);
    @(negedge clock);
    wait_grant();
    count0 = CW'($urandom);
    count1 = CW'($urandom);
    if (v.drop_at > 0) begin
      repeat (v.drop_at) @(negedge clock);
      req = req & ~v.exp_grant;
    end
    wait_done(v.exp_grant);
    req = req & ~v.exp_grant;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    vec_t v;
    //          req    c0      c1    drop  exp
    vecs[0] = '{2'b11, 8'd1,   8'd1, 0, 2'b01};  // tie after reset -> 0
    vecs[1] = '{2'b10, 8'd0,   8'd1, 0, 2'b10};  // leftover req[1]
    vecs[2] = '{2'b11, 8'd1,   8'd1, 0, 2'b01};  // tie again -> 0
    vecs[3] = '{2'b10, 8'd9,   8'd0, 0, 2'b10};  // zero-count request
    vecs[4] = '{2'b01, 8'd2,   8'd0, 0, 2'b01};  // two blinks
    vecs[5] = '{2'b01, 8'd3,   8'd0, 5, 2'b01};  // req dropped mid-ON
    vecs[6] = '{2'b10, 8'd0,   8'd3, 0, 2'b10};
    vecs[7] = '{2'b01, 8'd255, 8'd0, 0, 2'b01};  // max count, no wrap
    vecs[8] = '{2'b11, 8'd0,   8'd4, 0, 2'b10};  // tie after serving 0 -> 1
    vecs[9] = '{2'b01, 8'd0,   8'd0, 0, 2'b01};  // leftover req[0], zero count

    #3;
    check("rst_led", int'(led), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Reset asserted between edges during ON abandons the sequence
    wait_idle();
    count0 = 8'd2;
    req    = 2'b01;
    e.grant = 2'b01;
    e.cnt   = 2;
    sbq.push_back(e);
    @(negedge clock);
    wait_grant();
    repeat (5) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    sbq.push_back(e);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    wait_grant();
    wait_done(2'b01);
    req = 2'b00;
    wait_idle();
    repeat (3) @(negedge clock);

    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
